// File: rtl/note_sequencer.sv
// Note sequencer: plays a programmed table of {freq, waveform, duration} entries into the tone generator.
// Optional macro NOTE_SEQ_TEMPO_EN adds tempo_i for 1x/2x/4x/8x tick speed.
module note_sequencer #(
  parameter int depth_p     = 16,
  parameter int clk_freq_p  = 12_000_000,
  parameter int tick_hz_p   = 1000,
  parameter int gap_ticks_p = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
`ifdef NOTE_SEQ_TEMPO_EN
  input  logic [1:0]                 tempo_i,
`endif
  input  logic                       wr_v_i,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [15:0]                wr_freq_i,
  input  logic [3:0]                 wr_sw_i,
  input  logic [15:0]                wr_dur_i,
  input  logic [$clog2(depth_p):0]   len_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       loop_i,
  output logic [15:0]                freq_o,
  output logic [3:0]                 sw_o,
  output logic [$clog2(depth_p)-1:0] note_idx_o,
  output logic                       note_v_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int IW          = $clog2(depth_p);
  localparam int LW          = IW + 1;
  localparam int tick_div_lp = clk_freq_p / tick_hz_p;
  localparam int PW          = (tick_div_lp > 1) ? $clog2(tick_div_lp) : 1;
  localparam int GW          = (gap_ticks_p > 0) ? $clog2(gap_ticks_p + 1) : 1;
  localparam logic [PW-1:0] TERM      = PW'(tick_div_lp - 1);
  localparam logic [GW-1:0] GAP_TICKS = GW'(gap_ticks_p);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  // A zero duration still plays for one tick.
  function automatic logic [15:0] dur_floor(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  logic [15:0] freq_tab_q [depth_p];
  logic [3:0]  sw_tab_q   [depth_p];
  logic [15:0] dur_tab_q  [depth_p];

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, load_idx;
  logic [LW-1:0] len_q, len_d;
  logic [15:0]   dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   freq_q, freq_d;
  logic [3:0]    sw_q, sw_d;
  logic          note_v_q, note_v_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, adv, tick;
  logic [PW-1:0] term;

`ifdef NOTE_SEQ_TEMPO_EN
  logic [PW-1:0] term_q, term_d;

  function automatic logic [PW-1:0] tempo_term(input logic [1:0] t);
    int unsigned d;
    d = 32'(tick_div_lp) >> t;
    return (d == 0) ? '0 : PW'(d - 1);
  endfunction

  assign term = term_q;
`else
  assign term = TERM;
`endif

  assign tick = (state_q != IDLE) && (presc_q == term);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < depth_p; i++) begin
        freq_tab_q[i] <= '0;
        sw_tab_q[i]   <= '0;
        dur_tab_q[i]  <= '0;
      end
    end else if (wr_v_i) begin
      freq_tab_q[wr_addr_i] <= wr_freq_i;
      sw_tab_q[wr_addr_i]   <= wr_sw_i;
      dur_tab_q[wr_addr_i]  <= wr_dur_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    presc_d  = presc_q;
    freq_d   = freq_q;
    sw_d     = sw_q;
    note_v_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    adv      = 1'b0;
`ifdef NOTE_SEQ_TEMPO_EN
    term_d   = term_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i && (len_i != '0)) begin
          len_d = len_i;
          load  = 1'b1;
        end
      end
      PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (dur_q == 16'd1) begin
            if (gap_ticks_p > 0) begin
              state_d = GAP;
              sw_d    = '0;
              gap_d   = GAP_TICKS;
            end else begin
              adv = 1'b1;
            end
          end else begin
            dur_d = dur_q - 16'd1;
          end
        end
      end
      GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (gap_q == GW'(1)) adv = 1'b1;
          else                 gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (({1'b0, idx_q} + LW'(1)) < len_q) begin
        load     = 1'b1;
        load_idx = idx_q + IW'(1);
      end else if (loop_i) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        sw_d    = '0;
        busy_d  = 1'b0;
      end
    end

    // Loading reads the registered table, so a same-cycle write is not yet visible.
    if (load) begin
      state_d  = PLAY;
      idx_d    = load_idx;
      freq_d   = freq_tab_q[load_idx];
      sw_d     = sw_tab_q[load_idx];
      dur_d    = dur_floor(dur_tab_q[load_idx]);
      presc_d  = '0;
      note_v_d = 1'b1;
      busy_d   = 1'b1;
    end

`ifdef NOTE_SEQ_TEMPO_EN
    if (tick || load) term_d = tempo_term(tempo_i);
`endif

    if (stop_i) begin
      state_d  = IDLE;
      idx_d    = '0;
      freq_d   = freq_q;
      sw_d     = '0;
      busy_d   = 1'b0;
      note_v_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      presc_q  <= '0;
      freq_q   <= 16'd440;
      sw_q     <= '0;
      note_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NOTE_SEQ_TEMPO_EN
      term_q   <= TERM;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      presc_q  <= presc_d;
      freq_q   <= freq_d;
      sw_q     <= sw_d;
      note_v_q <= note_v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NOTE_SEQ_TEMPO_EN
      term_q   <= term_d;
`endif
    end
  end

  assign freq_o     = freq_q;
  assign sw_o       = sw_q;
  assign note_idx_o = idx_q;
  assign note_v_o   = note_v_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected output timelines are built note by note from table contents.
module tb_note_sequencer;
  localparam int TPT  = 10;  // clock cycles per tick
  localparam int GAPT = 2;
  localparam logic [31:0] FREQ_M = 32'h07FF_F800;
  localparam logic [31:0] IDX_M  = 32'h0000_0078;

  typedef logic [31:0] rec_t;

  logic        clk = 1'b0;
  logic        reset_i, wr_v_i, start_i, stop_i, loop_i;
  logic [3:0]  wr_addr_i, wr_sw_i, sw_o, note_idx_o;
  logic [15:0] wr_freq_i, wr_dur_i, freq_o;
  logic [4:0]  len_i;
  logic        note_v_o, busy_o, done_o;
  logic [1:0]  tempo;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] mf [16];
  logic [3:0]  ms [16];
  logic [15:0] md [16];
  rec_t exp_q [$];

  note_sequencer #(.depth_p(16), .clk_freq_p(1000), .tick_hz_p(100), .gap_ticks_p(GAPT)) dut (
    .clk_i(clk), .reset_i(reset_i),
`ifdef NOTE_SEQ_TEMPO_EN
    .tempo_i(tempo),
`endif
    .wr_v_i(wr_v_i), .wr_addr_i(wr_addr_i), .wr_freq_i(wr_freq_i), .wr_sw_i(wr_sw_i),
    .wr_dur_i(wr_dur_i), .len_i(len_i), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
    .freq_o(freq_o), .sw_o(sw_o), .note_idx_o(note_idx_o), .note_v_o(note_v_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic rec_t pk(input logic [15:0] f, input logic [3:0] s, input int i,
                              input logic nv, input logic b, input logic d);
    return {5'd0, f, s, 4'(i), nv, b, d};
  endfunction

  function automatic rec_t obs();
    return pk(freq_o, sw_o, int'(note_idx_o), note_v_o, busy_o, done_o);
  endfunction

  task automatic chk(input string tag, input rec_t o, input rec_t e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, o, e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the next cycle.
  task automatic wr(input int a, input logic [15:0] f, input logic [3:0] s, input logic [15:0] d);
    wr_v_i = 1'b1; wr_addr_i = 4'(a); wr_freq_i = f; wr_sw_i = s; wr_dur_i = d;
    mf[a] = f; ms[a] = s; md[a] = d;
    @(posedge clk); #1;
    wr_v_i = 1'b0;
  endtask

  // Expected output of every cycle after start, derived from the note table.
  task automatic build_model(input int len, input bit lp, input int ncyc);
    rec_t one [$];
    int d;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      d = (md[k] == 16'd0) ? 1 : int'(md[k]);
      for (int c = 0; c < d * TPT; c++) exp_q.push_back(pk(mf[k], ms[k], k, c == 0, 1'b1, 1'b0));
      for (int c = 0; c < GAPT * TPT; c++) exp_q.push_back(pk(mf[k], 4'd0, k, 1'b0, 1'b1, 1'b0));
    end
    if (lp) begin
      one = exp_q;
      for (int i = 0; exp_q.size() < ncyc; i++) exp_q.push_back(one[i % one.size()]);
      while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    end else begin
      exp_q.push_back(pk(mf[len-1], 4'd0, len - 1, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(pk(mf[len-1], 4'd0, len - 1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic run_play(input string tag, input int len, input bit lp, input int ncyc,
                          input int wr_off, input int wa, input logic [15:0] wf,
                          input logic [3:0] ws, input logic [15:0] wd,
                          input bit wnew, input bit restart);
    int n;
    if (wr_off >= 0 && wnew) begin mf[wa] = wf; ms[wa] = ws; md[wa] = wd; end
    build_model(len, lp, ncyc);
    if (wr_off >= 0 && !wnew) begin mf[wa] = wf; ms[wa] = ws; md[wa] = wd; end
    n = exp_q.size();
    if (restart) exp_q[n-1] = pk(mf[0], ms[0], 0, 1'b1, 1'b1, 1'b0);
    loop_i = lp;
    for (int c = 0; c <= n; c++) begin
      start_i = (c == 0) || (restart && c == n - 1);
      len_i   = start_i ? 5'(len) : 5'($urandom_range(0, 16));
      wr_v_i  = (c == wr_off);
      wr_addr_i = 4'(wa); wr_freq_i = wf; wr_sw_i = ws; wr_dur_i = wd;
      if (c > 0) begin
        @(negedge clk);
        chk(tag, obs(), exp_q[c-1]);
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0; wr_v_i = 1'b0; loop_i = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
    @(negedge clk);
    chk(tag, obs() & ~FREQ_M, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_i = 1'b1; wr_v_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    wr_addr_i = '0; wr_freq_i = '0; wr_sw_i = '0; wr_dur_i = '0; len_i = '0; tempo = 2'd0;
    for (int i = 0; i < 16; i++) begin mf[i] = '0; ms[i] = '0; md[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("reset", obs(), pk(16'd440, 4'd0, 0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;

    // Basic two-note sequence
    wr(0, 16'd440, 4'b0001, 16'd3);
    wr(1, 16'd880, 4'b0010, 16'd1);
    run_play("seq", 2, 1'b0, 0, -1, 0, '0, '0, '0, 1'b0, 1'b0);

    // Done and start in the same cycle
    run_play("restart", 2, 1'b0, 0, -1, 0, '0, '0, '0, 1'b0, 1'b1);
    do_stop("restart_stop");

    // Looping playback, then abort
    run_play("loop", 2, 1'b1, 300, -1, 0, '0, '0, '0, 1'b0, 1'b0);
    do_stop("loop_stop");

    // Stop and start together mid-note; start alone later
    len_i = 5'd2;
    for (int c = 0; c <= 21; c++) begin
      start_i = (c == 0) || (c == 15) || (c == 20);
      stop_i  = (c == 15);
      if (c == 1) begin @(negedge clk); chk("stp_first", obs(), pk(16'd440, 4'b0001, 0, 1'b1, 1'b1, 1'b0)); end
      if (c >= 16 && c <= 20) begin @(negedge clk); chk("stp_idle", obs() & ~FREQ_M, 32'd0); end
      if (c == 21) begin @(negedge clk); chk("stp_restart", obs(), pk(16'd440, 4'b0001, 0, 1'b1, 1'b1, 1'b0)); end
      @(posedge clk); #1;
    end
    start_i = 1'b0; stop_i = 1'b0;
    do_stop("stp_end");

    // Zero length start is ignored
    len_i = 5'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("len0", obs() & ~(FREQ_M | IDX_M), 32'd0);
      @(posedge clk); #1;
    end

    // Zero duration plays one tick
    wr(0, 16'd1000, 4'b0100, 16'd0);
    run_play("dur0", 1, 1'b0, 0, -1, 0, '0, '0, '0, 1'b0, 1'b0);
    wr(0, 16'd440, 4'b0001, 16'd3);

    // Write e1 while e0 plays: new contents used
    run_play("midwr", 2, 1'b0, 0, 5, 1, 16'd1234, 4'b1000, 16'd2, 1'b1, 1'b0);
    // Write e1 in its own load cycle: old contents used
    run_play("samewr", 2, 1'b0, 0, 3 * TPT + GAPT * TPT, 1, 16'd777, 4'b0001, 16'd1, 1'b0, 1'b0);

    // Random tables
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        wr(k, 16'($urandom_range(1, 20000)), 4'(1 << $urandom_range(0, 3)), 16'($urandom_range(0, 3)));
      run_play("rand", len, 1'b0, 0, -1, 0, '0, '0, '0, 1'b0, 1'b0);
    end

    // Reset mid-play clears outputs and table
    len_i = 5'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("reset_mid", obs(), pk(16'd440, 4'd0, 0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin mf[i] = '0; ms[i] = '0; md[i] = '0; end
    run_play("cleared", 1, 1'b0, 0, -1, 0, '0, '0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
